jtframe_vtimer_flex: RTL and testbench

Parametrised video timing generator, the successor to the fixed-geometry timer used by every core's video top. It derives horizontal and vertical counters, blanking, sync, and look-ahead render line numbers from a pixel clock enable. Unlike the fixed timer it adds two things: fully parametrised counter widths and totals, and run-time sync position trimming (screen centering) applied glitch-free at frame boundaries. It sits between the clock-enable generator and the gfx/colmix blocks of a core's video top.

---
 rtl/jtframe_vtimer_pkg.sv | 38 +++
 rtl/jtframe_vtimer_win.sv | 38 +++
 rtl/jtframe_vtimer_flex.sv | 145 ++++++++++++++
 tb/tb_jtframe_vtimer_flex.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_vtimer_pkg.sv
// Shared constants and arithmetic for the flexible video timer.
//   - DEF_*   : default geometry (384x264 total, 256x224 visible).
//   - mod_add : modular add of an unsigned counter value and a signed
//               4-bit offset. The result is assumed to be in [0,total)
//               provided a < total and |off| <= total.
package jtframe_vtimer_pkg;

  localparam int DEF_W        = 9;
  localparam int DEF_H_TOTAL  = 384;
  localparam int DEF_HB_START = 256;
  localparam int DEF_HB_END   = 0;
  localparam int DEF_HS_START = 296;
  localparam int DEF_HS_LEN   = 32;
  localparam int DEF_V_TOTAL  = 264;
  localparam int DEF_VB_START = 240;
  localparam int DEF_VB_END   = 16;
  localparam int DEF_VS_START = 252;
  localparam int DEF_VS_LEN   = 3;

  // Arithmetic width: the W+1-bit signed sum for any W up to AW-1.
  localparam int AW = 16;
  typedef logic [AW-1:0] arith_t;

  // Sign-extend the offset, add, then fold back into range with a single
  // add or subtract of the total.
  function automatic arith_t mod_add(input arith_t a,
                                     input logic [3:0] off,
                                     input arith_t total);
    logic signed [AW:0] s;
    logic signed [AW:0] tot;
    tot = $signed({1'b0, total});
    s   = $signed({1'b0, a}) + $signed({{(AW-3){off[3]}}, off});
    if (s[AW])         s = s + tot;
    else if (s >= tot) s = s - tot;
    return s[AW-1:0];
  endfunction

endpackage

// File: rtl/jtframe_vtimer_win.sv
// Registered wrap-aware window comparator.
//   flag_o is (val_i lies in [start_i, start_i+len_i) mod TOTAL) ^ INV,
//   re-evaluated only on cycles where upd_i is high. len_i==0 yields an
//   empty window, i.e. a constant flag.
// Ports: clk, rst_n (async, active low, flag resets to 0), upd_i, val_i,
//        start_i, len_i, flag_o.
module jtframe_vtimer_win #(
  parameter int W     = 9,
  parameter int TOTAL = 384,
  parameter bit INV   = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         upd_i,
  input  logic [W-1:0] val_i,
  input  logic [W-1:0] start_i,
  input  logic [W-1:0] len_i,
  output logic         flag_o
);

  logic [W:0] diff;
  logic       flag_d, flag_q;

  // Distance from start to value going forward around the ring.
  always_comb begin
    if (val_i >= start_i) diff = {1'b0, val_i} - {1'b0, start_i};
    else                  diff = {1'b0, val_i} + (W+1)'(TOTAL) - {1'b0, start_i};
    flag_d = (diff < {1'b0, len_i}) ^ INV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     flag_q <= 1'b0;
    else if (upd_i) flag_q <= flag_d;
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/jtframe_vtimer_flex.sv
// Parametrised video timing generator with frame-synchronous sync trimming.
// Ports:
//   clk, rst_n (async, active low), pxl_cen (pixel enable)
//   hs_adj, vs_adj : signed -8..+7 sync offsets, latched at frame start
//   H, vdump, vrender (=vdump+1), vrender1 (=vdump+2) : counters
//   Hinit, Vinit : last pixel of line / of frame
//   LHBL, LVBL (active-low blanks), HS, VS (active-high syncs), frame
// Build option: VTIMER_SYNC_ADJ_EN enables the hs_adj/vs_adj latches; when
// undefined the adj inputs are ignored and sync sits at HS_START/VS_START.
module jtframe_vtimer_flex
  import jtframe_vtimer_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int HB_START = DEF_HB_START,
  parameter int HB_END   = DEF_HB_END,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_LEN   = DEF_HS_LEN,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int VB_START = DEF_VB_START,
  parameter int VB_END   = DEF_VB_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_LEN   = DEF_VS_LEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pxl_cen,
  input  logic [3:0]   hs_adj,
  input  logic [3:0]   vs_adj,
  output logic [W-1:0] H,
  output logic [W-1:0] vdump,
  output logic [W-1:0] vrender,
  output logic [W-1:0] vrender1,
  output logic         Hinit,
  output logic         Vinit,
  output logic         LHBL,
  output logic         LVBL,
  output logic         HS,
  output logic         VS,
  output logic         frame
);

  localparam int HB_LEN = (HB_END - HB_START + H_TOTAL) % H_TOTAL;
  localparam int VB_LEN = (VB_END - VB_START + V_TOTAL) % V_TOTAL;
  localparam logic [W-1:0] H_LAST = W'(H_TOTAL - 1);
  localparam logic [W-1:0] V_LAST = W'(V_TOTAL - 1);

  logic [W-1:0] h_q, h_d, vd_q, vd_d, vr_q, vr_d, vr1_q, vr1_d;
  logic         hinit_q, vinit_q, frame_q;
  logic [3:0]   hs_adj_l, vs_adj_l;
  logic [W-1:0] hs_e, vs_e;

`ifdef VTIMER_SYNC_ADJ_EN
  // Offsets only move at the frame boundary so a frame never sees two
  // different sync positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_adj_l <= '0;
      vs_adj_l <= '0;
    end else if (pxl_cen && vinit_q) begin
      hs_adj_l <= hs_adj;
      vs_adj_l <= vs_adj;
    end
  end
`else
  logic unused_adj;
  assign unused_adj = ^{hs_adj, vs_adj};
  assign hs_adj_l   = '0;
  assign vs_adj_l   = '0;
`endif

  assign hs_e = W'(mod_add(arith_t'(HS_START), hs_adj_l, arith_t'(H_TOTAL)));
  assign vs_e = W'(mod_add(arith_t'(VS_START), vs_adj_l, arith_t'(V_TOTAL)));

  // Next-state counters; every flag below is derived from these so flags
  // line up with the counter value they describe.
  always_comb begin
    h_d  = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    vd_d = vd_q;
    if (h_q == H_LAST) vd_d = (vd_q == V_LAST) ? '0 : vd_q + 1'b1;
    vr_d  = W'(mod_add(arith_t'(vd_d), 4'd1, arith_t'(V_TOTAL)));
    vr1_d = W'(mod_add(arith_t'(vd_d), 4'd2, arith_t'(V_TOTAL)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      vd_q    <= '0;
      vr_q    <= W'(1);
      vr1_q   <= W'(2);
      hinit_q <= 1'b0;
      vinit_q <= 1'b0;
      frame_q <= 1'b0;
    end else if (pxl_cen) begin
      h_q     <= h_d;
      vd_q    <= vd_d;
      vr_q    <= vr_d;
      vr1_q   <= vr1_d;
      hinit_q <= (h_d == H_LAST);
      vinit_q <= (h_d == H_LAST) && (vd_d == V_LAST);
      if (vinit_q) frame_q <= ~frame_q;
    end
  end

  // Horizontal blank: only touched at its two edges.
  jtframe_vtimer_win #(.W(W), .TOTAL(H_TOTAL), .INV(1'b1)) u_hbl (
    .clk(clk), .rst_n(rst_n),
    .upd_i  (pxl_cen && (h_d == W'(HB_START) || h_d == W'(HB_END))),
    .val_i  (h_d), .start_i(W'(HB_START)), .len_i(W'(HB_LEN)),
    .flag_o (LHBL)
  );

  // Vertical blank looks at the line about to be drawn, sampled at HB start.
  jtframe_vtimer_win #(.W(W), .TOTAL(V_TOTAL), .INV(1'b1)) u_vbl (
    .clk(clk), .rst_n(rst_n),
    .upd_i  (pxl_cen && (h_d == W'(HB_START))),
    .val_i  (vr_d), .start_i(W'(VB_START)), .len_i(W'(VB_LEN)),
    .flag_o (LVBL)
  );

  // HS is evaluated every pixel so a new offset can never leave it stuck.
  jtframe_vtimer_win #(.W(W), .TOTAL(H_TOTAL), .INV(1'b0)) u_hs (
    .clk(clk), .rst_n(rst_n),
    .upd_i  (pxl_cen),
    .val_i  (h_d), .start_i(hs_e), .len_i(W'(HS_LEN)),
    .flag_o (HS)
  );

  // VS edges are aligned to the HS leading edge.
  jtframe_vtimer_win #(.W(W), .TOTAL(V_TOTAL), .INV(1'b0)) u_vs (
    .clk(clk), .rst_n(rst_n),
    .upd_i  (pxl_cen && (h_d == hs_e)),
    .val_i  (vd_d), .start_i(vs_e), .len_i(W'(VS_LEN)),
    .flag_o (VS)
  );

  assign H        = h_q;
  assign vdump    = vd_q;
  assign vrender  = vr_q;
  assign vrender1 = vr1_q;
  assign Hinit    = hinit_q;
  assign Vinit    = vinit_q;
  assign frame    = frame_q;

endmodule

// File: tb/tb_jtframe_vtimer_flex.sv
// Bench for jtframe_vtimer_flex on a reduced 48x20 geometry so that many
// frames fit in a short run. A reference model derives every output from
// the count of pixel enables since reset and the sync/blank window rules.
module tb_jtframe_vtimer_flex;

  localparam int W = 6, HT = 48, HBS = 36, HBE = 4, HSS = 40, HSL = 6;
  localparam int VT = 20, VBS = 16, VBE = 2, VSS = 3, VSL = 3;
  localparam int F = HT * VT;
`ifdef VTIMER_SYNC_ADJ_EN
  localparam bit ADJ = 1'b1;
`else
  localparam bit ADJ = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b0;
  logic [3:0]   hs_adj = '0, vs_adj = '0;
  logic [W-1:0] H, vdump, vrender, vrender1;
  logic         Hinit, Vinit, LHBL, LVBL, HS, VS, frame;

  jtframe_vtimer_flex #(
    .W(W), .H_TOTAL(HT), .HB_START(HBS), .HB_END(HBE), .HS_START(HSS),
    .HS_LEN(HSL), .V_TOTAL(VT), .VB_START(VBS), .VB_END(VBE),
    .VS_START(VSS), .VS_LEN(VSL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .hs_adj(hs_adj),
    .vs_adj(vs_adj), .H(H), .vdump(vdump), .vrender(vrender),
    .vrender1(vrender1), .Hinit(Hinit), .Vinit(Vinit), .LHBL(LHBL),
    .LVBL(LVBL), .HS(HS), .VS(VS), .frame(frame)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (n=%0d, t=%0t)", nm, act, exp, n, $time);
    end
  endtask

  function automatic int sx4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic int wrap(input int v, input int tot);
    return ((v % tot) + tot) % tot;
  endfunction

  // Membership in a ring window, enumerated element by element.
  function automatic bit in_ring(input int v, input int s, input int len, input int tot);
    for (int i = 0; i < len; i++)
      if (wrap(s + i, tot) == v) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- reference model ----------------
  int n = 0;                 // pixel enables since reset
  int lat_hs = 0, lat_vs = 0;
  bit m_lhbl = 0, m_lvbl = 0, m_hs = 0, m_vs = 0;

  initial forever begin : mdl
    int h, vd, vr, hs_e, vs_e;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n = 0; lat_hs = 0; lat_vs = 0;
      m_lhbl = 0; m_lvbl = 0; m_hs = 0; m_vs = 0;
    end else if (pxl_cen) begin
      n++;
      h  = n % HT;
      vd = (n / HT) % VT;
      vr = (vd + 1) % VT;
      hs_e = wrap(HSS + lat_hs, HT);
      vs_e = wrap(VSS + lat_vs, VT);
      if (h == HBS) m_lhbl = 0;
      if (h == HBE) m_lhbl = 1;
      if (h == HBS) m_lvbl = !in_ring(vr, VBS, wrap(VBE - VBS, VT), VT);
      m_hs = in_ring(h, hs_e, HSL, HT);
      if (h == hs_e) m_vs = in_ring(vd, vs_e, VSL, VT);
      if (ADJ && (n % F == 0)) begin
        lat_hs = sx4(hs_adj);
        lat_vs = sx4(vs_adj);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin : cmp
    int vd;
    @(negedge clk);
    vd = (n / HT) % VT;
    chk("H",        int'(H),        n % HT);
    chk("vdump",    int'(vdump),    vd);
    chk("vrender",  int'(vrender),  (vd + 1) % VT);
    chk("vrender1", int'(vrender1), (vd + 2) % VT);
    chk("Hinit",    int'(Hinit),    int'(n % HT == HT - 1));
    chk("Vinit",    int'(Vinit),    int'(n % HT == HT - 1 && vd == VT - 1));
    chk("frame",    int'(frame),    (n / F) % 2);
    chk("LHBL",     int'(LHBL),     int'(m_lhbl));
    chk("LVBL",     int'(LVBL),     int'(m_lvbl));
    chk("HS",       int'(HS),       int'(m_hs));
    chk("VS",       int'(VS),       int'(m_vs));
  end

  // ---------------- stimulus ----------------
  task automatic wait_n(input int target);
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk); #1;
      if (n == target) return;
      pxl_cen = ($urandom_range(0, 3) != 0);
    end
    nvec++; nerr++;
    $display("FAIL wait_n: timeout, got n=%0d expected %0d", n, target);
  endtask

  task automatic run_random(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk); #1;
      pxl_cen = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) hs_adj = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) vs_adj = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("rst_H", int'(H), 0);
    chk("rst_vrender", int'(vrender), 1);
    chk("rst_vrender1", int'(vrender1), 2);
    chk("rst_LHBL", int'(LHBL), 0);
    chk("rst_HS", int'(HS), 0);

    // Frame 0: nominal positions whatever is on the adj inputs.
    hs_adj = 4'd7; vs_adj = 4'b1000;
    wait_n(4);   chk("lit_LHBL_rise", int'(LHBL), 1);
    wait_n(35);  chk("lit_LHBL_pre", int'(LHBL), 1);
    wait_n(36);  chk("lit_LHBL_fall", int'(LHBL), 0);
    wait_n(40);  chk("lit_HS_rise", int'(HS), 1);
    wait_n(45);  chk("lit_HS_last", int'(HS), 1);
    wait_n(46);  chk("lit_HS_fall", int'(HS), 0);
    wait_n(83);  chk("lit_LVBL_pre", int'(LVBL), 0);
    wait_n(84);  chk("lit_LVBL_rise", int'(LVBL), 1);
    wait_n(100);
    chk("lit_vdump", int'(vdump), 2);
    chk("lit_vrender1", int'(vrender1), 4);
    wait_n(183); chk("lit_VS_pre", int'(VS), 0);
    wait_n(184); chk("lit_VS_rise", int'(VS), 1);
    wait_n(327); chk("lit_VS_last", int'(VS), 1);
    wait_n(328); chk("lit_VS_fall", int'(VS), 0);
    wait_n(959);
    chk("lit_Vinit", int'(Vinit), 1);
    chk("lit_frame0", int'(frame), 0);
    wait_n(960);
    chk("lit_frame1", int'(frame), 1);
    chk("lit_Vinit_off", int'(Vinit), 0);
`ifdef VTIMER_SYNC_ADJ_EN
    // Frame 1: hs_e = 47 (window wraps through 0), vs_e = 15.
    wait_n(1000); chk("adj_HS_old_pos", int'(HS), 0);
    wait_n(1007); chk("adj_HS_rise", int'(HS), 1);
    wait_n(1010); chk("adj_HS_wrapped", int'(HS), 1);
    wait_n(1013); chk("adj_HS_fall", int'(HS), 0);
    wait_n(1726); chk("adj_VS_pre", int'(VS), 0);
    wait_n(1727); chk("adj_VS_rise", int'(VS), 1);
    wait_n(1870); chk("adj_VS_last", int'(VS), 1);
    wait_n(1871); chk("adj_VS_fall", int'(VS), 0);
`else
    wait_n(1000); chk("noadj_HS_rise", int'(HS), 1);
    wait_n(1005); chk("noadj_HS_last", int'(HS), 1);
    wait_n(1006); chk("noadj_HS_fall", int'(HS), 0);
    wait_n(1143); chk("noadj_VS_pre", int'(VS), 0);
    wait_n(1144); chk("noadj_VS_rise", int'(VS), 1);
`endif

    run_random(15000);

    // Enable held low: the per-cycle compare shows everything frozen.
    pxl_cen = 1'b0;
    repeat (100) @(negedge clk);

    // Asynchronous reset in the middle of a frame.
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clk); #1;
      if (n % HT == 15 && (n / HT) % VT == 10) found = 1'b1;
      else pxl_cen = ($urandom_range(0, 3) != 0);
    end
    chk("reach_mid_frame", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_H", int'(H), 0);
    chk("arst_vdump", int'(vdump), 0);
    chk("arst_vrender", int'(vrender), 1);
    chk("arst_vrender1", int'(vrender1), 2);
    chk("arst_LVBL", int'(LVBL), 0);
    chk("arst_frame", int'(frame), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1; pxl_cen = 1'b1;
    @(negedge clk); #1;
    chk("resume_H", int'(H), 1);
    chk("resume_vrender", int'(vrender), 1);
    chk("resume_vrender1", int'(vrender1), 2);

    run_random(8000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
